// File: rtl/vga_window_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_window_arbiter_pkg
// Brief    : Shared encodings for the overlay window compositor.
// Revision : 1.0 - initial release
// ============================================================================
package vga_window_arbiter_pkg;

  localparam int VGA_CNTR_BIT_WIDTH = 11;

  localparam logic [2:0] CFG_X_LO   = 3'd0;
  localparam logic [2:0] CFG_X_HI   = 3'd1;
  localparam logic [2:0] CFG_Y_LO   = 3'd2;
  localparam logic [2:0] CFG_Y_HI   = 3'd3;
  localparam logic [2:0] CFG_FILL   = 3'd4;
  localparam logic [2:0] CFG_BORDER = 3'd5;
  localparam logic [2:0] CFG_CTRL   = 3'd6;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_BORDER_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } cfg_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_window_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_window_arbiter_if
// Brief    : Pixel stream, configuration and composited-output bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_window_arbiter_if #(
  parameter int N_WIN   = 4,
  parameter int CW      = 11,
  parameter int COLOR_W = 8
) ();
  localparam int WIN_W = $clog2(N_WIN);

  logic [CW-1:0]      X;
  logic [CW-1:0]      Y;
  logic               pix_valid;
  logic               vblank_start;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [WIN_W-1:0]   cfg_win;
  logic [2:0]         cfg_field;
  logic [CW-1:0]      cfg_data;
  logic               cfg_commit;
  logic               commit_busy;
  logic               commit_done;
  logic               pix_out_valid;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_hit;
  logic [WIN_W-1:0]   pix_win;
  logic               pix_border;

  modport master (
    output X, Y, pix_valid, vblank_start, cfg_valid, cfg_win, cfg_field,
           cfg_data, cfg_commit,
    input  cfg_ready, commit_busy, commit_done, pix_out_valid, pix_color,
           pix_hit, pix_win, pix_border
  );

  modport slave (
    input  X, Y, pix_valid, vblank_start, cfg_valid, cfg_win, cfg_field,
           cfg_data, cfg_commit,
    output cfg_ready, commit_busy, commit_done, pix_out_valid, pix_color,
           pix_hit, pix_win, pix_border
  );
endinterface
`default_nettype wire

// File: rtl/vga_window_arbiter_match.sv
`default_nettype none
// ============================================================================
// Module   : vga_win_match
// Brief    : Registered hit/border compare of one window against the pixel.
// Revision : 1.0 - initial release
// ============================================================================
module vga_win_match #(
  parameter int CW = 11
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic [CW-1:0] i_x,
  input  wire logic [CW-1:0] i_y,
  input  wire logic          i_pix_valid,
  input  wire logic [CW-1:0] i_x_lo,
  input  wire logic [CW-1:0] i_x_hi,
  input  wire logic [CW-1:0] i_y_lo,
  input  wire logic [CW-1:0] i_y_hi,
  input  wire logic          i_en,
  input  wire logic          i_border_en,
  output logic               o_hit,
  output logic               o_border
);
  logic w_in_x;
  logic w_in_y;
  logic w_hit;
  logic w_edge;

  // Half-open ranges make lo >= hi naturally empty.
  assign w_in_x = (i_x >= i_x_lo) && (i_x < i_x_hi);
  assign w_in_y = (i_y >= i_y_lo) && (i_y < i_y_hi);
  assign w_hit  = i_pix_valid && i_en && w_in_x && w_in_y;
  assign w_edge = (i_x == i_x_lo) || (i_x == i_x_hi - CW'(1)) ||
                  (i_y == i_y_lo) || (i_y == i_y_hi - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hit    <= 1'b0;
      o_border <= 1'b0;
    end else begin
      o_hit    <= w_hit;
      o_border <= w_hit && i_border_en && w_edge;
    end
  end
endmodule
`default_nettype wire

// File: rtl/vga_window_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_window_arbiter
// Brief    : Shadow/active window config with frame-boundary commit and a
//            two-stage fixed-priority pixel compositor.
// Revision : 1.0 - initial release
// ============================================================================
module vga_window_arbiter
  import vga_window_arbiter_pkg::*;
#(
  parameter int                 N_WIN    = 4,
  parameter int                 CW       = VGA_CNTR_BIT_WIDTH,
  parameter int                 COLOR_W  = 8,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  vga_window_arbiter_if.slave   bus
);
  localparam int WIN_W = $clog2(N_WIN);
  localparam logic [WIN_W:0] c_N_WIN = (WIN_W+1)'(N_WIN);

  cfg_state_t r_state;
  cfg_state_t w_next;
  logic       w_ready;
  logic       w_busy;
  logic       w_done;
  logic       w_wr;

  logic [CW-1:0]      r_sh_xlo [N_WIN];
  logic [CW-1:0]      r_sh_xhi [N_WIN];
  logic [CW-1:0]      r_sh_ylo [N_WIN];
  logic [CW-1:0]      r_sh_yhi [N_WIN];
  logic [COLOR_W-1:0] r_sh_fcol[N_WIN];
  logic [COLOR_W-1:0] r_sh_bcol[N_WIN];
  logic [N_WIN-1:0]   r_sh_en;
  logic [N_WIN-1:0]   r_sh_ben;

  logic [CW-1:0]      r_ac_xlo [N_WIN];
  logic [CW-1:0]      r_ac_xhi [N_WIN];
  logic [CW-1:0]      r_ac_ylo [N_WIN];
  logic [CW-1:0]      r_ac_yhi [N_WIN];
  logic [COLOR_W-1:0] r_ac_fcol[N_WIN];
  logic [COLOR_W-1:0] r_ac_bcol[N_WIN];
  logic [N_WIN-1:0]   r_ac_en;
  logic [N_WIN-1:0]   r_ac_ben;

  logic [N_WIN-1:0]   w_s1_hit;
  logic [N_WIN-1:0]   w_s1_border;
  logic               r_s1_valid;

  logic               w_hit;
  logic [WIN_W-1:0]   w_win;
  logic               w_border;
  logic [COLOR_W-1:0] w_color;
  logic               r_out_valid;
  logic               r_out_hit;
  logic [WIN_W-1:0]   r_out_win;
  logic               r_out_border;
  logic [COLOR_W-1:0] r_out_color;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // vblank_start is only looked at once PENDING, so a coincident pulse in IDLE is dropped.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.cfg_commit) w_next = ST_PENDING;
      end
      ST_PENDING: begin
        w_busy = 1'b1;
        if (bus.vblank_start) w_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_wr = bus.cfg_valid && w_ready && ({1'b0, bus.cfg_win} < c_N_WIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WIN; i++) begin
        r_sh_xlo[i]  <= '0;
        r_sh_xhi[i]  <= '0;
        r_sh_ylo[i]  <= '0;
        r_sh_yhi[i]  <= '0;
        r_sh_fcol[i] <= '0;
        r_sh_bcol[i] <= '0;
        r_ac_xlo[i]  <= '0;
        r_ac_xhi[i]  <= '0;
        r_ac_ylo[i]  <= '0;
        r_ac_yhi[i]  <= '0;
        r_ac_fcol[i] <= '0;
        r_ac_bcol[i] <= '0;
      end
      r_sh_en  <= '0;
      r_sh_ben <= '0;
      r_ac_en  <= '0;
      r_ac_ben <= '0;
    end else begin
      if (w_wr) begin
        case (bus.cfg_field)
          CFG_X_LO:   r_sh_xlo[bus.cfg_win]  <= bus.cfg_data;
          CFG_X_HI:   r_sh_xhi[bus.cfg_win]  <= bus.cfg_data;
          CFG_Y_LO:   r_sh_ylo[bus.cfg_win]  <= bus.cfg_data;
          CFG_Y_HI:   r_sh_yhi[bus.cfg_win]  <= bus.cfg_data;
          CFG_FILL:   r_sh_fcol[bus.cfg_win] <= bus.cfg_data[COLOR_W-1:0];
          CFG_BORDER: r_sh_bcol[bus.cfg_win] <= bus.cfg_data[COLOR_W-1:0];
          CFG_CTRL: begin
            r_sh_en[bus.cfg_win]  <= bus.cfg_data[CTRL_EN_BIT];
            r_sh_ben[bus.cfg_win] <= bus.cfg_data[CTRL_BORDER_BIT];
          end
          default: ;
        endcase
      end
      if (r_state == ST_COMMIT) begin
        r_ac_xlo  <= r_sh_xlo;
        r_ac_xhi  <= r_sh_xhi;
        r_ac_ylo  <= r_sh_ylo;
        r_ac_yhi  <= r_sh_yhi;
        r_ac_fcol <= r_sh_fcol;
        r_ac_bcol <= r_sh_bcol;
        r_ac_en   <= r_sh_en;
        r_ac_ben  <= r_sh_ben;
      end
    end
  end

  generate
    for (genvar g = 0; g < N_WIN; g++) begin : g_win
      vga_win_match #(.CW(CW)) u_match (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_x         (bus.X),
        .i_y         (bus.Y),
        .i_pix_valid (bus.pix_valid),
        .i_x_lo      (r_ac_xlo[g]),
        .i_x_hi      (r_ac_xhi[g]),
        .i_y_lo      (r_ac_ylo[g]),
        .i_y_hi      (r_ac_yhi[g]),
        .i_en        (r_ac_en[g]),
        .i_border_en (r_ac_ben[g]),
        .o_hit       (w_s1_hit[g]),
        .o_border    (w_s1_border[g])
      );
    end
  endgenerate

  // Walk from lowest priority upward so the lowest hitting index is left standing.
  always_comb begin
    w_hit    = 1'b0;
    w_win    = '0;
    w_border = 1'b0;
    w_color  = BG_COLOR;
    for (int i = N_WIN - 1; i >= 0; i--) begin
      if (w_s1_hit[i]) begin
        w_hit    = 1'b1;
        w_win    = WIN_W'(i);
        w_border = w_s1_border[i];
        w_color  = w_s1_border[i] ? r_ac_bcol[i] : r_ac_fcol[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_hit    <= 1'b0;
      r_out_win    <= '0;
      r_out_border <= 1'b0;
      r_out_color  <= BG_COLOR;
    end else begin
      r_s1_valid   <= bus.pix_valid;
      r_out_valid  <= r_s1_valid;
      r_out_hit    <= w_hit;
      r_out_win    <= w_win;
      r_out_border <= w_border;
      r_out_color  <= w_color;
    end
  end

  assign bus.cfg_ready     = w_ready;
  assign bus.commit_busy   = w_busy;
  assign bus.commit_done   = w_done;
  assign bus.pix_out_valid = r_out_valid;
  assign bus.pix_hit       = r_out_hit;
  assign bus.pix_win       = r_out_win;
  assign bus.pix_border    = r_out_border;
  assign bus.pix_color     = r_out_color;
endmodule
`default_nettype wire

// File: tb/tb_vga_window_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_window_arbiter
// Brief    : Directed vector bench for the overlay window compositor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_window_arbiter;
  import vga_window_arbiter_pkg::*;

  localparam int N_WIN   = 3;
  localparam int CW      = 11;
  localparam int COLOR_W = 8;
  localparam int WIN_W   = 2;

  typedef struct {
    int phase;
    int x;
    int y;
    bit v;
    bit ev;
    bit eh;
    int ew;
    bit eb;
    int ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  vga_window_arbiter_if #(.N_WIN(N_WIN), .CW(CW), .COLOR_W(COLOR_W)) bus ();

  vga_window_arbiter #(
    .N_WIN    (N_WIN),
    .CW       (CW),
    .COLOR_W  (COLOR_W),
    .BG_COLOR (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int w, input int f, input int d);
    int guard;
    guard = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_win   = WIN_W'(w);
    bus.cfg_field = 3'(f);
    bus.cfg_data  = CW'(d);
    while (!bus.cfg_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!bus.cfg_ready) chk("wr_ready_timeout", 0, 1);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic do_commit(input string nm);
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    chk({nm, "_busy_pend"}, int'(bus.commit_busy), 1);
    chk({nm, "_ready_pend"}, int'(bus.cfg_ready), 0);
    tick();
    chk({nm, "_done_pend"}, int'(bus.commit_done), 0);
    bus.vblank_start = 1'b1;
    tick();
    bus.vblank_start = 1'b0;
    chk({nm, "_done"}, int'(bus.commit_done), 1);
    tick();
    chk({nm, "_done_after"}, int'(bus.commit_done), 0);
    chk({nm, "_busy_after"}, int'(bus.commit_busy), 0);
  endtask

  task automatic pix(input string nm, input int x, input int y, input bit v, input bit ev,
                     input bit eh, input int ew, input bit eb, input int ec);
    bus.X = CW'(x);
    bus.Y = CW'(y);
    bus.pix_valid = v;
    tick();
    bus.pix_valid = 1'b0;
    tick();
    chk({nm, "_valid"}, int'(bus.pix_out_valid), int'(ev));
    chk({nm, "_hit"}, int'(bus.pix_hit), int'(eh));
    chk({nm, "_win"}, int'(bus.pix_win), ew);
    chk({nm, "_border"}, int'(bus.pix_border), int'(eb));
    chk({nm, "_color"}, int'(bus.pix_color), ec);
  endtask

  task automatic run_phase(input int p);
    foreach (tbl[i]) begin
      if (tbl[i].phase == p)
        pix($sformatf("p%0d_v%0d", p, i), tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].ev,
            tbl[i].eh, tbl[i].ew, tbl[i].eb, tbl[i].ec);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ready"}, int'(bus.cfg_ready), 1);
    chk({nm, "_busy"}, int'(bus.commit_busy), 0);
    chk({nm, "_done"}, int'(bus.commit_done), 0);
    chk({nm, "_ovalid"}, int'(bus.pix_out_valid), 0);
    chk({nm, "_hit"}, int'(bus.pix_hit), 0);
    chk({nm, "_win"}, int'(bus.pix_win), 0);
    chk({nm, "_border"}, int'(bus.pix_border), 0);
    chk({nm, "_color"}, int'(bus.pix_color), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //           phase  x   y  v  ev eh w  b  colour
    tbl.push_back('{1, 10,  5, 1, 1, 0, 0, 0, 8'h00});
    tbl.push_back('{1, 100, 50, 1, 1, 0, 0, 0, 8'h00});
    tbl.push_back('{2, 10,  5, 1, 1, 0, 0, 0, 8'h00});
    tbl.push_back('{3, 10,  5, 1, 1, 1, 0, 0, 8'h1C});
    tbl.push_back('{3, 20,  5, 1, 1, 0, 0, 0, 8'h00});
    tbl.push_back('{3, 19,  7, 1, 1, 1, 0, 0, 8'h1C});
    tbl.push_back('{3,  9,  5, 1, 1, 0, 0, 0, 8'h00});
    tbl.push_back('{3, 10,  8, 1, 1, 0, 0, 0, 8'h00});
    tbl.push_back('{3, 10,  4, 1, 1, 0, 0, 0, 8'h00});
    tbl.push_back('{4,  5,  6, 1, 1, 1, 0, 0, 8'h1C});
    tbl.push_back('{4, 15,  6, 1, 1, 1, 1, 1, 8'hE0});
    tbl.push_back('{4, 10,  6, 1, 1, 1, 1, 0, 8'h33});
    tbl.push_back('{4, 10,  5, 1, 1, 1, 1, 1, 8'hE0});
    tbl.push_back('{4,  4,  7, 1, 1, 1, 0, 0, 8'h1C});
    tbl.push_back('{4, 16,  6, 1, 1, 0, 0, 0, 8'h00});
    tbl.push_back('{4, 50,  6, 1, 1, 0, 0, 0, 8'h00});
    tbl.push_back('{4,  5,  6, 0, 0, 0, 0, 0, 8'h00});

    bus.X = '0; bus.Y = '0; bus.pix_valid = 1'b1; bus.vblank_start = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_win = '0; bus.cfg_field = '0; bus.cfg_data = '0;
    bus.cfg_commit = 1'b0;

    // Reset with pixel traffic applied
    tick(); tick();
    check_reset_outputs("rst0");
    bus.pix_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    run_phase(1);

    // Basic commit: shadow writes invisible until committed
    wr(0, CFG_X_LO, 10); wr(0, CFG_X_HI, 20);
    wr(0, CFG_Y_LO, 5);  wr(0, CFG_Y_HI, 8);
    wr(0, CFG_FILL, 8'h1C); wr(0, CFG_CTRL, 1);
    run_phase(2);
    do_commit("basic");
    run_phase(3);

    // Priority, border, empty window, ignored writes
    wr(0, CFG_X_LO, 0); wr(0, CFG_X_HI, 8);
    wr(1, CFG_X_LO, 4); wr(1, CFG_X_HI, 16);
    wr(1, CFG_Y_LO, 5); wr(1, CFG_Y_HI, 8);
    wr(1, CFG_FILL, 8'h33); wr(1, CFG_BORDER, 8'hE0); wr(1, CFG_CTRL, 3);
    wr(2, CFG_X_LO, 50); wr(2, CFG_X_HI, 50);
    wr(2, CFG_Y_LO, 0);  wr(2, CFG_Y_HI, 100);
    wr(2, CFG_FILL, 8'h77); wr(2, CFG_CTRL, 1);
    wr(0, 7, 0);
    wr(1, 7, 0);
    wr(3, CFG_CTRL, 0);
    wr(3, CFG_FILL, 8'hFF);
    do_commit("prio");
    run_phase(4);

    // Write held during PENDING waits for IDLE and stays in shadow
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_win = 2'd0; bus.cfg_field = CFG_FILL; bus.cfg_data = CW'(8'h55);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hs_ready_pend%0d", k), int'(bus.cfg_ready), 0);
      tick();
    end
    bus.vblank_start = 1'b1;
    tick();
    bus.vblank_start = 1'b0;
    chk("hs_ready_commit", int'(bus.cfg_ready), 0);
    chk("hs_done_commit", int'(bus.commit_done), 1);
    tick();
    chk("hs_ready_idle", int'(bus.cfg_ready), 1);
    tick();
    bus.cfg_valid = 1'b0;
    pix("hs_old", 5, 6, 1, 1, 1, 0, 0, 8'h1C);
    do_commit("hs");
    pix("hs_new", 5, 6, 1, 1, 1, 0, 0, 8'h55);

    // Write + commit + vblank in one IDLE cycle
    bus.cfg_valid = 1'b1; bus.cfg_win = 2'd0; bus.cfg_field = CFG_FILL; bus.cfg_data = CW'(8'h66);
    bus.cfg_commit = 1'b1; bus.vblank_start = 1'b1;
    tick();
    bus.cfg_valid = 1'b0; bus.cfg_commit = 1'b0; bus.vblank_start = 1'b0;
    chk("sim_busy", int'(bus.commit_busy), 1);
    chk("sim_done0", int'(bus.commit_done), 0);
    tick();
    chk("sim_done1", int'(bus.commit_done), 0);
    pix("sim_old", 5, 6, 1, 1, 1, 0, 0, 8'h55);
    bus.vblank_start = 1'b1;
    tick();
    bus.vblank_start = 1'b0;
    chk("sim_done", int'(bus.commit_done), 1);
    tick();
    pix("sim_new", 5, 6, 1, 1, 1, 0, 0, 8'h66);

    // Reset mid-commit discards pending commit and shadow
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    chk("mrst_busy", int'(bus.commit_busy), 1);
    bus.X = CW'(5); bus.Y = CW'(6); bus.pix_valid = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mrst");
    bus.pix_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.vblank_start = 1'b1;
    tick();
    bus.vblank_start = 1'b0;
    chk("mrst_no_commit", int'(bus.commit_done), 0);
    pix("mrst_bg", 5, 6, 1, 1, 0, 0, 0, 8'h00);
    do_commit("mrst");
    pix("mrst_shadow_cleared", 5, 6, 1, 1, 0, 0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
